// File: rtl/ymat_pkg.sv
// Shared types and default widths for the Y-matrix row fetch path.
package ymat_pkg;
  localparam int YMAT_ADDR_W = 11;
  localparam int YMAT_DATA_W = 16;
  localparam int YMAT_SHIFT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } ymat_fetch_state_t;

  typedef struct packed {
    logic [YMAT_DATA_W-1:0] data;
    logic                   last;
  } ymat_word_t;
endpackage

// File: rtl/ymat_skid_fifo.sv
// Two-entry FIFO absorbing SRAM returns while the stream is stalled.
module ymat_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign count = count_q;
endmodule

// File: rtl/ymat_row_fetch.sv
// Streams one Y-matrix row from SRAM, scaled by 2^-SHIFT, onto a valid/ready port.
// Define YMAT_ROUND_EN for round-to-nearest scaling instead of truncation.
module ymat_row_fetch
  import ymat_pkg::*;
#(
  parameter int ADDR_W  = YMAT_ADDR_W,
  parameter int DATA_W  = YMAT_DATA_W,
  parameter int ROW_LEN = 32,
  parameter int SHIFT   = YMAT_SHIFT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_base,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  ymat_fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [ADDR_W:0]   iss_q, iss_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   fifo_head;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic              pop, issue, last_issue;
  logic [2:0]        occ;
  logic [DATA_W-1:0] scaled;

  assign pop        = fifo_valid & out_ready;
  // Occupancy after this cycle's pop, counting the read already on its way back.
  assign occ        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == FETCH) && (occ < 3'd2);
  assign last_issue = issue && (iss_q == (ADDR_W+1)'(ROW_LEN - 1));

`ifdef YMAT_ROUND_EN
  localparam logic [DATA_W:0] RND = (DATA_W+1)'(1) << (SHIFT - 1);
  always_comb scaled = DATA_W'($signed({sram_rdata[DATA_W-1], sram_rdata} + RND) >>> SHIFT);
`else
  always_comb scaled = $signed(sram_rdata) >>> SHIFT;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    iss_d       = iss_q;
    done_d      = 1'b0;
    hold_d      = issue ? addr_q : hold_q;
    inflight_d  = issue;
    infl_last_d = last_issue;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        addr_d  = row_base;
        iss_d   = '0;
      end
      FETCH: if (issue) begin
        addr_d = addr_q + 1'b1;
        iss_d  = iss_q + 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: if (pop && fifo_head[DATA_W]) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      hold_q      <= '0;
      iss_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      iss_q       <= iss_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  ymat_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clock),
    .clr       (reset),
    .push      (inflight_q),
    .push_data ({infl_last_q, scaled}),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign sram_rd_en = issue;
  assign sram_addr  = issue ? addr_q : hold_q;
  assign out_valid  = fifo_valid;
  assign out_data   = fifo_valid ? fifo_head[DATA_W-1:0] : '0;
  assign out_last   = fifo_valid & fifo_head[DATA_W];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
endmodule

// File: tb/tb_ymat_row_fetch.sv
// Scoreboard bench: a 4-word instance (basic, wrap, back-to-back, ignored start)
// and a 32-word instance (backpressure, reset mid-row).
module tb_ymat_row_fetch;
  import ymat_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst_a = 1'b1, start_a = 1'b0, ready_a = 1'b1;
  logic [10:0] base_a = '0, addr_a;
  logic [15:0] rdata_a = '0, data_a;
  logic        rd_a, valid_a, last_a, busy_a, done_a;

  logic        rst_b = 1'b1, start_b = 1'b0, ready_b = 1'b1;
  logic [10:0] base_b = '0, addr_b;
  logic [15:0] rdata_b = '0, data_b;
  logic        rd_b, valid_b, last_b, busy_b, done_b;

  ymat_row_fetch #(.ADDR_W(11), .DATA_W(16), .ROW_LEN(4), .SHIFT(4)) dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .row_base(base_a),
    .sram_rd_en(rd_a), .sram_addr(addr_a), .sram_rdata(rdata_a),
    .out_valid(valid_a), .out_data(data_a), .out_last(last_a), .out_ready(ready_a),
    .busy(busy_a), .done(done_a));

  ymat_row_fetch #(.ADDR_W(11), .DATA_W(16), .ROW_LEN(32), .SHIFT(4)) dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .row_base(base_b),
    .sram_rd_en(rd_b), .sram_addr(addr_b), .sram_rdata(rdata_b),
    .out_valid(valid_b), .out_data(data_b), .out_last(last_b), .out_ready(ready_b),
    .busy(busy_b), .done(done_b));

  function automatic logic [15:0] sram_word(input logic [10:0] a);
    case (a)
      11'h010: return 16'h0100;
      11'h011: return 16'hFFF0;
      11'h012: return 16'h0018;
      11'h013: return 16'h7FFF;
      default: return {a, 5'b10110};
    endcase
  endfunction

  // Reference scaling by floor division on integers.
  function automatic logic [15:0] scale_ref(input logic [15:0] w);
    int v, m;
    v = int'($signed(w));
`ifdef YMAT_ROUND_EN
    v = v + 8;
`endif
    m = ((v % 16) + 16) % 16;
    return 16'((v - m) / 16);
  endfunction

  always @(posedge clk) begin
    if (rd_a) rdata_a <= sram_word(addr_a);
    if (rd_b) rdata_b <= sram_word(addr_b);
  end

  ymat_word_t  exp_a[$], exp_b[$];
  logic [10:0] eaddr_a[$], eaddr_b[$];
  ymat_word_t  ew_a, ew_b;
  logic [10:0] ea_a, ea_b;
  int          first_v_a = -1;
  int          hs_b = 0;
  logic        stalled_b = 1'b0;
  logic [16:0] held_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_row(input bit sel, input logic [10:0] base, input int len);
    logic [10:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 11'(i);
      if (sel) begin
        eaddr_b.push_back(a);
        exp_b.push_back('{data: scale_ref(sram_word(a)), last: (i == len - 1)});
      end else begin
        eaddr_a.push_back(a);
        exp_a.push_back('{data: scale_ref(sram_word(a)), last: (i == len - 1)});
      end
    end
  endtask

  task automatic wait_done(input bit sel, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_done sel=%0d got none expected done pulse", sel);
    end
  endtask

  // Monitor for the 4-word instance.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (rd_a) begin
        checks++;
        if (eaddr_a.size() == 0) begin
          errors++;
          $display("FAIL a_rd_addr got %h expected no read", addr_a);
        end else begin
          ea_a = eaddr_a.pop_front();
          if (addr_a !== ea_a) begin
            errors++;
            $display("FAIL a_rd_addr got %h expected %h", addr_a, ea_a);
          end
        end
      end
      if (valid_a && first_v_a < 0) first_v_a = cyc;
      if (valid_a && ready_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL a_word got %h/%b expected none", data_a, last_a);
        end else begin
          ew_a = exp_a.pop_front();
          if (data_a !== ew_a.data || last_a !== ew_a.last) begin
            errors++;
            $display("FAIL a_word got %h/%b expected %h/%b", data_a, last_a, ew_a.data, ew_a.last);
          end
        end
      end
    end
  end

  // Monitor for the 32-word instance, including stall stability and occupancy.
  always @(negedge clk) begin
    if (!rst_b) begin
      if (rd_b) begin
        checks++;
        if (eaddr_b.size() == 0) begin
          errors++;
          $display("FAIL b_rd_addr got %h expected no read", addr_b);
        end else begin
          ea_b = eaddr_b.pop_front();
          if (addr_b !== ea_b) begin
            errors++;
            $display("FAIL b_rd_addr got %h expected %h", addr_b, ea_b);
          end
        end
      end
      if (stalled_b) begin
        checks++;
        if (!valid_b || {last_b, data_b} !== held_b) begin
          errors++;
          $display("FAIL b_stall_hold got %b/%h expected 1/%h", valid_b, {last_b, data_b}, held_b);
        end
      end
      stalled_b = valid_b && !ready_b;
      held_b    = {last_b, data_b};
      if (busy_b) begin
        checks++;
        if (dut_b.u_fifo.count_q > 2'd2) begin
          errors++;
          $display("FAIL b_fifo_count got %0d expected <=2", dut_b.u_fifo.count_q);
        end
      end
      if (valid_b && ready_b) begin
        hs_b++;
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b_word got %h/%b expected none", data_b, last_b);
        end else begin
          ew_b = exp_b.pop_front();
          if (data_b !== ew_b.data || last_b !== ew_b.last) begin
            errors++;
            $display("FAIL b_word got %h/%b expected %h/%b", data_b, last_b, ew_b.data, ew_b.last);
          end
        end
      end
    end else begin
      stalled_b = 1'b0;
    end
  end

`ifdef YMAT_ROUND_EN
  localparam logic [15:0] BASIC_EXP [4] = '{16'h0010, 16'hFFFF, 16'h0002, 16'h0800};
`else
  localparam logic [15:0] BASIC_EXP [4] = '{16'h0010, 16'hFFFF, 16'h0001, 16'h07FF};
`endif

  logic [15:0] pat = 16'b1001_0110_1100_1001;

  initial begin
    int c0, at;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset_a_outputs", 32'({rd_a, addr_a, valid_a, data_a, last_a, busy_a, done_a}), 32'd0);
    chk("reset_b_outputs", 32'({rd_b, addr_b, valid_b, data_b, last_b, busy_b, done_b}), 32'd0);

    // Basic row with hand-computed results.
    for (int i = 0; i < 4; i++) begin
      eaddr_a.push_back(11'h010 + 11'(i));
      exp_a.push_back('{data: BASIC_EXP[i], last: (i == 3)});
    end
    @(posedge clk); #1;
    start_a = 1'b1; base_a = 11'h010; c0 = cyc; first_v_a = -1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, 50, at);
    chk("basic_done_cycle", 32'(at - c0), 32'd7);
    chk("basic_first_valid", 32'(first_v_a - c0), 32'd3);

    // Back-to-back start in the done cycle, also exercising address wrap.
    push_row(1'b0, 11'h7FE, 4);
    start_a = 1'b1; base_a = 11'h7FE; c0 = cyc;
    @(negedge clk);
    chk("b2b_rd_en", 32'(rd_a), 32'd1);
    chk("b2b_rd_cycle", 32'(cyc - c0), 32'd1);
    start_a = 1'b0;
    wait_done(1'b0, 50, at);
    chk("wrap_done_cycle", 32'(at - c0), 32'd7);
    chk("wrap_addr_hold", 32'(addr_a), 32'h001);

    // Start pulsed mid-row must be ignored.
    push_row(1'b0, 11'h020, 4);
    @(posedge clk); #1;
    start_a = 1'b1; base_a = 11'h020;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b1; base_a = 11'h100;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, 50, at);
    repeat (10) @(negedge clk);
    chk("ignored_start_idle", 32'(busy_a), 32'd0);
    chk("ignored_start_drained", 32'(exp_a.size() + eaddr_a.size()), 32'd0);

    // Backpressure over a 32-word row.
    hs_b = 0;
    push_row(1'b1, 11'h040, 32);
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 11'h040;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      ready_b = pat[k % 16];
      if (done_b) break;
    end
    chk("bp_done_seen", 32'(done_b), 32'd1);
    chk("bp_handshakes", 32'(hs_b), 32'd32);
    chk("bp_drained", 32'(exp_b.size() + eaddr_b.size()), 32'd0);

    // Reset after five words; late return must not appear.
    ready_b = 1'b1; hs_b = 0;
    push_row(1'b1, 11'h200, 32);
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 11'h200;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (hs_b >= 5) break;
    end
    chk("rst_five_words", 32'(hs_b), 32'd5);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({rd_b, addr_b, valid_b, data_b, last_b, busy_b, done_b}), 32'd0);
    chk("rst_mid_state", 32'(dut_b.state_q), 32'(IDLE));
    #1;
    rst_b = 1'b0;
    exp_b.delete();
    eaddr_b.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_late_word", 32'({valid_b, rd_b}), 32'd0);
    end
    hs_b = 0;
    push_row(1'b1, 11'h300, 32);
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 11'h300;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_done(1'b1, 100, at);
    chk("rst_fresh_handshakes", 32'(hs_b), 32'd32);
    chk("rst_fresh_drained", 32'(exp_b.size() + eaddr_b.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
